gf2_rref: RTL and testbench

- Gauss-Jordan eliminator over GF(2); sits directly upstream of enumerate_solutions.
- Loads one augmented matrix on start and reduces it in place to reduced row-echelon form.
- Presents RREF rows, rank, pivot mask and an inconsistency flag; a one-cycle done pulse drives the enumerator's start.

---
 rtl/gf2_rref_pkg.sv | 29 ++
 rtl/gf2_rref_if.sv | 45 ++++
 rtl/gf2_rref_pivot_find.sv | 35 +++
 rtl/gf2_rref.sv | 199 +++++++++++++++++++
 tb/tb_gf2_rref.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2_rref_pkg.sv
// -----------------------------------------------------------------------------
// gf2_pkg -- shared types and width helpers for the GF(2) Gauss-Jordan
// eliminator (gf2_rref) and its pivot finder.
//   state_e : FSM encoding (IDLE, PIVOT, ELIM), also exported on state_o.
//   rank_w  : width able to hold 0..rows (rank and the pivot-row pointer).
//   row_w   : width of a row index 0..rows-1.
//   col_w   : width of a column index 0..cols-1.
// -----------------------------------------------------------------------------
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PIVOT = 2'd1,
    ELIM  = 2'd2
  } state_e;

  function automatic int rank_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int col_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/gf2_rref_if.sv
// -----------------------------------------------------------------------------
// gf2_rref_if -- request/result bundle of the GF(2) eliminator.
//   start/matrix        : request; matrix is sampled on the edge that accepts
//                         start (start is only accepted while busy=0).
//   busy/done           : busy spans the run; done is a one-cycle pulse.
//   rref_valid/RREF     : result rows, stable while rref_valid=1.
//   rank/pivot_mask     : pivot count and per-variable pivot flags.
//   inconsistent        : some non-pivot row carries a set RHS bit.
//   cycle_count         : processing cycles of the last run (0 when the
//                         counter is not built).
// Handshake: start is a level request, accepted on any rising edge where the
// eliminator is idle (busy=0); there is no back-pressure on the results,
// which simply hold until the next accepted start.
// Modports: slave = eliminator, master = requester.
// -----------------------------------------------------------------------------
interface gf2_rref_if #(
  parameter int ROWS = 4,
  parameter int COLS = 7
);
  import gf2_pkg::*;

  logic                      start;
  logic [COLS-1:0]           matrix [ROWS];
  logic                      busy;
  logic                      done;
  logic                      rref_valid;
  logic [COLS-1:0]           RREF [ROWS];
  logic [rank_w(ROWS)-1:0]   rank;
  logic [COLS-2:0]           pivot_mask;
  logic                      inconsistent;
  logic [15:0]               cycle_count;

  modport slave (
    input  start, matrix,
    output busy, done, rref_valid, RREF, rank, pivot_mask, inconsistent,
           cycle_count
  );

  modport master (
    output start, matrix,
    input  busy, done, rref_valid, RREF, rank, pivot_mask, inconsistent,
           cycle_count
  );

endinterface

// File: rtl/gf2_rref_pivot_find.sv
// -----------------------------------------------------------------------------
// gf2_pivot_find -- combinational priority encoder picking the lowest row
// index >= prow_i whose bit in the current column is set.
//   col_bits_i : bit col of every row (bit r = row r).
//   prow_i     : first row still eligible to become a pivot row.
//   found_o    : a candidate exists.
//   row_o      : index of the lowest candidate (0 when found_o=0).
// -----------------------------------------------------------------------------
module gf2_pivot_find
  import gf2_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic [ROWS-1:0]         col_bits_i,
  input  logic [rank_w(ROWS)-1:0] prow_i,
  output logic                    found_o,
  output logic [row_w(ROWS)-1:0]  row_o
);

  localparam int RANK_W = rank_w(ROWS);
  localparam int ROW_W  = row_w(ROWS);

  // Scanning downwards lets the lowest eligible row win the final assignment.
  always_comb begin
    found_o = 1'b0;
    row_o   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (col_bits_i[i] && (RANK_W'(i) >= prow_i)) begin
        found_o = 1'b1;
        row_o   = ROW_W'(i);
      end
    end
  end

endmodule

// File: rtl/gf2_rref.sv
// -----------------------------------------------------------------------------
// gf2_rref -- in-place Gauss-Jordan elimination of an augmented ROWS x COLS
// matrix over GF(2). Bits COLS-2..0 of a row are variables, bit COLS-1 is
// the right-hand side.
// Ports:
//   clk     : rising-edge clock.
//   rst     : asynchronous active-high reset; aborts any run.
//   bus     : gf2_rref_if.slave (start/matrix in, results out).
//   state_o : current FSM state, for observation.
// Optional build macro: GF2_RREF_CYCLE_COUNT_EN adds a saturating 16-bit
// processing-cycle counter behind bus.cycle_count; otherwise it reads 0.
// -----------------------------------------------------------------------------
module gf2_rref
  import gf2_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst,
  gf2_rref_if.slave  bus,
  output state_e     state_o
);

  localparam int RANK_W = rank_w(ROWS);
  localparam int ROW_W  = row_w(ROWS);
  localparam int COL_W  = col_w(COLS);
  localparam int VARS   = COLS - 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [RANK_W-1:0] ROW_END  = RANK_W'(ROWS);

  state_e              state_q, state_d;
  logic [COLS-1:0]     rows_q [ROWS];
  logic [COLS-1:0]     rows_d [ROWS];
  logic [COL_W-1:0]    col_q, col_d;
  logic [RANK_W-1:0]   prow_q, prow_d;
  logic [RANK_W-1:0]   rank_q, rank_d;
  logic [VARS-1:0]     mask_q, mask_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  logic [ROWS-1:0]     col_bits;
  logic                piv_found;
  logic [ROW_W-1:0]    piv_row;
  logic [ROW_W-1:0]    prow_idx;
  logic                incons;

  // prow never reaches ROWS while in PIVOT/ELIM, so the narrow index is safe.
  assign prow_idx = prow_q[ROW_W-1:0];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      col_bits[r] = rows_q[r][col_q];
    end
  end

  gf2_pivot_find #(.ROWS(ROWS)) u_pivot_find (
    .col_bits_i (col_bits),
    .prow_i     (prow_q),
    .found_o    (piv_found),
    .row_o      (piv_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= '0;
      end
      col_q   <= '0;
      prow_q  <= '0;
      rank_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      col_q   <= col_d;
      prow_q  <= prow_d;
      rank_q  <= rank_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    col_d   = col_q;
    prow_d  = prow_q;
    rank_d  = rank_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rows_d  = bus.matrix;
          col_d   = '0;
          prow_d  = '0;
          rank_d  = '0;
          mask_d  = '0;
          valid_d = 1'b0;
          state_d = PIVOT;
        end
      end

      PIVOT: begin
        if (piv_found) begin
          // Swap is a no-op when the pivot already sits at prow.
          rows_d[prow_idx] = rows_q[piv_row];
          rows_d[piv_row]  = rows_q[prow_idx];
          mask_d           = mask_q | (VARS'(1) << col_q);
          state_d          = ELIM;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      ELIM: begin
        // Clearing above and below the pivot gives reduced (not just
        // echelon) form in a single pass.
        for (int r = 0; r < ROWS; r++) begin
          if ((ROW_W'(r) != prow_idx) && rows_q[r][col_q]) begin
            rows_d[r] = rows_q[r] ^ rows_q[prow_idx];
          end
        end
        prow_d  = prow_q + 1'b1;
        rank_d  = rank_q + 1'b1;
        col_d   = col_q + 1'b1;
        state_d = PIVOT;
      end

      default: state_d = IDLE;
    endcase

    // Run ends on the same edge that exhausts variables or rows.
    if ((state_q != IDLE) && ((col_d == COL_LAST) || (prow_d == ROW_END))) begin
      state_d = IDLE;
      done_d  = 1'b1;
      valid_d = 1'b1;
    end
  end

  // Rows at or below rank are all-zero in the variable columns; a set RHS
  // there is the contradiction 0 = 1.
  always_comb begin
    incons = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if ((RANK_W'(r) >= rank_q) && rows_q[r][COLS-1]) begin
        incons = 1'b1;
      end
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.rref_valid   = valid_q;
  assign bus.RREF         = rows_q;
  assign bus.rank         = rank_q;
  assign bus.pivot_mask   = mask_q;
  assign bus.inconsistent = incons;
  assign state_o          = state_q;

`ifdef GF2_RREF_CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cc_q;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // cnt_q counts the run in progress; cc_q publishes it on the done edge,
  // including the final processing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cc_q  <= '0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        cnt_q <= '0;
      end
    end else begin
      cnt_q <= cnt_inc;
      if (done_d) begin
        cc_q <= cnt_inc;
      end
    end
  end

  assign bus.cycle_count = cc_q;
`else
  assign bus.cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_gf2_rref.sv
module tb_gf2_rref;
  import gf2_pkg::*;

`ifdef GF2_RREF_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gf2_rref_if #(.ROWS(2), .COLS(3)) bus_a ();
  gf2_rref_if #(.ROWS(3), .COLS(4)) bus_b ();
  state_e st_a;
  state_e st_b;

  gf2_rref #(.ROWS(2), .COLS(3)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .state_o (st_a)
  );

  gf2_rref #(.ROWS(3), .COLS(4)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .state_o (st_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  logic [2:0][3:0] got_rref;
  int              got_rank;
  logic [2:0]      got_mask;
  logic            got_inc;
  logic            got_done;
  logic            got_valid;
  logic            got_busy;
  logic [15:0]     got_cc;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit              use_b;
    logic [2:0][3:0] mat;
    logic [2:0][3:0] exp;
    int              rank;
    logic [2:0]      mask;
    bit              inc;
    int              lat;
  } vec_t;

  vec_t vecs [8];

  // ---------------- driver tasks ----------------
  task automatic run_a(input logic [2:0][3:0] m, output int lat);
    for (int r = 0; r < 2; r++) bus_a.matrix[r] = m[r][2:0];
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    lat = 0;
    while (!bus_a.done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_b(input logic [2:0][3:0] m, output int lat);
    for (int r = 0; r < 3; r++) bus_b.matrix[r] = m[r];
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    lat = 0;
    while (!bus_b.done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic capture(input bit b);
    got_rref = '0;
    if (b) begin
      for (int r = 0; r < 3; r++) got_rref[r] = bus_b.RREF[r];
      got_rank  = 32'(bus_b.rank);
      got_mask  = bus_b.pivot_mask;
      got_inc   = bus_b.inconsistent;
      got_done  = bus_b.done;
      got_valid = bus_b.rref_valid;
      got_busy  = bus_b.busy;
      got_cc    = bus_b.cycle_count;
    end else begin
      for (int r = 0; r < 2; r++) got_rref[r] = {1'b0, bus_a.RREF[r]};
      got_rank  = 32'(bus_a.rank);
      got_mask  = {1'b0, bus_a.pivot_mask};
      got_inc   = bus_a.inconsistent;
      got_done  = bus_a.done;
      got_valid = bus_a.rref_valid;
      got_busy  = bus_a.busy;
      got_cc    = bus_a.cycle_count;
    end
  endtask

  task automatic do_vec(input int i);
    int lat;
    int nr;
    logic [3:0] exp_row;
    nr = vecs[i].use_b ? 3 : 2;
    if (vecs[i].use_b) run_b(vecs[i].mat, lat);
    else               run_a(vecs[i].mat, lat);
    capture(vecs[i].use_b);
    check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    check($sformatf("v%0d_done", i), 32'(got_done), 32'(1));
    check($sformatf("v%0d_valid", i), 32'(got_valid), 32'(1));
    check($sformatf("v%0d_busy", i), 32'(got_busy), 32'(0));
    for (int r = 0; r < nr; r++) exp_q.push_back(vecs[i].exp[r]);
    for (int r = 0; r < nr; r++) begin
      exp_row = exp_q.pop_front();
      check($sformatf("v%0d_rref%0d", i, r), 32'(got_rref[r]), 32'(exp_row));
    end
    check($sformatf("v%0d_rank", i), got_rank, vecs[i].rank);
    check($sformatf("v%0d_mask", i), 32'(got_mask), 32'(vecs[i].mask));
    check($sformatf("v%0d_incons", i), 32'(got_inc), 32'(vecs[i].inc));
    check($sformatf("v%0d_cycles", i), 32'(got_cc),
          CC_EN ? vecs[i].lat : 0);
    @(posedge clk); #1;
    capture(vecs[i].use_b);
    check($sformatf("v%0d_done_pulse", i), 32'(got_done), 32'(0));
    check($sformatf("v%0d_valid_hold", i), 32'(got_valid), 32'(1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int lat;
    int n;
    int busy_cnt;
    int low_cnt;
    bit saw_done;

    // {row2, row1, row0}; 2x3 rows occupy the low 3 bits of each slot.
    vecs[0] = '{0, {4'h0, 4'b0011, 4'b0110}, {4'h0, 4'b0110, 4'b0101}, 2, 3'b011, 0, 4};
    vecs[1] = '{0, {4'h0, 4'b0000, 4'b0100}, {4'h0, 4'b0000, 4'b0100}, 0, 3'b000, 1, 2};
    vecs[2] = '{0, {4'h0, 4'b0010, 4'b0001}, {4'h0, 4'b0010, 4'b0001}, 2, 3'b011, 0, 4};
    vecs[3] = '{0, {4'h0, 4'b0111, 4'b0111}, {4'h0, 4'b0000, 4'b0111}, 1, 3'b001, 0, 3};
    vecs[4] = '{0, {4'h0, 4'b0001, 4'b0101}, {4'h0, 4'b0100, 4'b0101}, 1, 3'b001, 1, 3};
    vecs[5] = '{1, {4'b0110, 4'b0011, 4'b0011}, {4'b0000, 4'b0110, 4'b0101}, 2, 3'b011, 0, 5};
    vecs[6] = '{1, {4'b0010, 4'b0100, 4'b1000}, {4'b1000, 4'b0100, 4'b0010}, 2, 3'b110, 1, 5};
    vecs[7] = '{1, {4'b0011, 4'b0101, 4'b0111}, {4'b0100, 4'b0010, 4'b0001}, 3, 3'b111, 0, 6};

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int r = 0; r < 2; r++) bus_a.matrix[r] = '0;
    for (int r = 0; r < 3; r++) bus_b.matrix[r] = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    capture(1'b1);
    check("rst_busy", 32'(got_busy), 32'(0));
    check("rst_done", 32'(got_done), 32'(0));
    check("rst_valid", 32'(got_valid), 32'(0));
    check("rst_rank", got_rank, 0);
    check("rst_mask", 32'(got_mask), 32'(0));
    check("rst_rref", 32'(got_rref), 32'(0));
    check("rst_cycles", 32'(got_cc), 32'(0));
    check("rst_state_b", 32'(st_b), 32'(IDLE));
    check("rst_state_a", 32'(st_a), 32'(IDLE));

    // Table-driven runs.
    for (int i = 0; i < 8; i++) do_vec(i);

    // Start pulses during busy are ignored (3x4 case).
    for (int r = 0; r < 3; r++) bus_b.matrix[r] = vecs[5].mat[r];
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    for (int r = 0; r < 3; r++) bus_b.matrix[r] = 4'hF;
    n = 0;
    busy_cnt = 0;
    while (n < 20) begin
      if (bus_b.busy) busy_cnt++;
      bus_b.start = (n == 1 || n == 3);
      @(posedge clk); #1;
      n++;
      if (bus_b.done) break;
    end
    bus_b.start = 1'b0;
    capture(1'b1);
    check("busy_start_done", 32'(got_done), 32'(1));
    check("busy_start_busycycles", busy_cnt, 5);
    check("busy_start_rref", 32'(got_rref), 32'({4'b0000, 4'b0110, 4'b0101}));
    check("busy_start_rank", got_rank, 2);
    check("busy_start_mask", 32'(got_mask), 32'(3'b011));
    @(posedge clk); #1;
    check("busy_start_idle", 32'(bus_b.busy), 32'(0));

    // Start accepted in the cycle done is high (2x3).
    run_a(vecs[0].mat, lat);
    check("b2b_first_latency", lat, 4);
    bus_a.matrix[0] = 3'b100;
    bus_a.matrix[1] = 3'b000;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    low_cnt = 0;
    check("b2b_busy_after_accept", 32'(bus_a.busy), 32'(1));
    for (int k = 0; k < 8 && !bus_a.rref_valid; k++) begin
      low_cnt++;
      @(posedge clk); #1;
    end
    capture(1'b0);
    check("b2b_valid_low_cycles", low_cnt, 2);
    check("b2b_done", 32'(got_done), 32'(1));
    check("b2b_incons", 32'(got_inc), 32'(1));
    check("b2b_rank", got_rank, 0);
    check("b2b_rref", 32'(got_rref), 32'({4'h0, 4'b0000, 4'b0100}));
    check("b2b_cycles", 32'(got_cc), CC_EN ? 2 : 0);

    // Reset mid-run: asynchronous clear, no done, then a clean rerun.
    for (int r = 0; r < 3; r++) bus_b.matrix[r] = vecs[5].mat[r];
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 32'(bus_b.busy), 32'(1));
    rst = 1'b1;
    #1;
    capture(1'b1);
    check("midrst_busy", 32'(got_busy), 32'(0));
    check("midrst_done", 32'(got_done), 32'(0));
    check("midrst_valid", 32'(got_valid), 32'(0));
    check("midrst_rank", got_rank, 0);
    check("midrst_mask", 32'(got_mask), 32'(0));
    check("midrst_rref", 32'(got_rref), 32'(0));
    check("midrst_cycles", 32'(got_cc), 32'(0));
    check("midrst_state", 32'(st_b), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_b.done) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'(0));
    do_vec(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
